// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues reads to a 1-cycle synchronous instruction memory,
// buffers {pc, instr} pairs in a prefetch FIFO and presents them over valid/ready.

module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 19,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  inflight_pc_r;
  logic               inflight_r;
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W:0]     reserved_s;

  // Issue reserves a FIFO slot for the in-flight read, so overflow cannot occur.
  always_comb begin
    reserved_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s    = !reset && !redirect_valid && !halt && (reserved_s < DEPTH_C);
    push_s     = inflight_r && !redirect_valid;
    pop_s      = (count_r != {CNT_W{1'b0}}) && if_ready;
  end

  // Head presentation; an empty FIFO shows zeros rather than stale storage.
  always_comb begin
    if_valid = (count_r != {CNT_W{1'b0}});
    if (if_valid) begin
      if_instr = instr_mem_r[rd_ptr_r];
      if_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      if_instr = {INSTR_W{1'b0}};
      if_pc    = {ADDR_W{1'b0}};
    end
  end

  assign imem_en    = issue_s;
  assign imem_addr  = fetch_pc_r;
  assign fifo_count = count_r;
  assign idle       = (count_r == {CNT_W{1'b0}}) && !inflight_r;

  // Fetch PC, in-flight tracking and FIFO pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      inflight_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + ADDR_W'(1'b1);
        inflight_pc_r <= fetch_pc_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO payload storage; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
    end
  end

  instr_fetch_unit_chk #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// Protocol checker: a push must never land in a full prefetch FIFO.
module instr_fetch_unit_chk #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (count == FULL_C)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model of
// the fetch stream (expected PCs held in a queue, memory contents as a function of address).

module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [18:0] if_instr;
  logic [15:0] if_pc;
  logic [2:0]  fifo_count;
  logic        idle;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_fetch_pc;
  bit          m_inflight;
  logic [15:0] m_inflight_pc;
  logic [15:0] m_q[$];

  instr_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (19),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fifo_count     (fifo_count),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mem_val(input logic [15:0] a);
    return {3'b000, a} + 19'h00100;
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_val(imem_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, advance the model past the edge.
  task automatic step(input bit r, input bit rv, input logic [15:0] rpc, input bit h, input bit rdy);
    bit en_exp;
    reset = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    halt = h;
    if_ready = rdy;
    #1;
    en_exp = !r && !rv && !h && ((m_q.size() + int'(m_inflight)) < DEPTH);
    check_val("imem_en", {31'd0, imem_en}, {31'd0, en_exp});
    if (en_exp) check_val("imem_addr", {16'd0, imem_addr}, {16'd0, m_fetch_pc});
    check_val("if_valid", {31'd0, if_valid}, {31'd0, (m_q.size() != 0)});
    check_val("fifo_count", {29'd0, fifo_count}, 32'(m_q.size()));
    check_val("idle", {31'd0, idle}, {31'd0, (m_q.size() == 0) && !m_inflight});
    if (m_q.size() != 0) begin
      check_val("if_pc", {16'd0, if_pc}, {16'd0, m_q[0]});
      check_val("if_instr", {13'd0, if_instr}, {13'd0, mem_val(m_q[0])});
    end
    if (r) begin
      m_fetch_pc = 16'h0000;
      m_inflight = 1'b0;
      m_q.delete();
    end else if (rv) begin
      m_fetch_pc = rpc;
      m_inflight = 1'b0;
      m_q.delete();
    end else begin
      if ((m_q.size() != 0) && rdy) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      if (en_exp) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 16'h0001;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit r;
    bit rv;
    bit h;
    bit rdy;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
    if_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_fetch_pc = 16'h0000;
    m_inflight = 1'b0;
    m_q.delete();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Post-reset output values
    reset = 1'b0;
    #1;
    check_val("rst_if_instr", {13'd0, if_instr}, 32'd0);
    check_val("rst_if_pc", {16'd0, if_pc}, 32'd0);

    // Streaming with downstream always ready
    repeat (12) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Backpressure then release
    repeat (10) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Redirect with buffered entries and a read in flight
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Address wrap
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Halt mid-stream, drain, resume
    repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Reset with a full FIFO
    repeat (6) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Back-to-back redirects: last wins
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Redirect while halted: restart waits for halt release
    step(1'b0, 1'b1, 16'h0200, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Random traffic
    h = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(199) == 0);
      rv = !r && ($urandom_range(19) == 0);
      if ($urandom_range(9) == 0) h = !h;
      rdy = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0)
        step(r, rv, 16'hFFFC + 16'($urandom_range(7)), h, rdy);
      else
        step(r, rv, 16'($urandom), h, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage feeding the 19-bit CPU decode/execute stage. It reads 19-bit instruction words from a synchronous instruction memory (1-cycle read latency) and buffers them, each tagged with its PC, in a small prefetch FIFO. It presents them downstream over a valid/ready handshake. It handles redirects (jump, taken branch, call, return) by flushing buffered and in-flight fetches and restarting at the new PC.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 19, instruction word width (opcode[18:14], r1[13:10], r2[9:6], r3/addr[5:0])
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_en  output  1  instruction memory read strobe
imem_addr  output  ADDR_W  read address, valid when imem_en=1
imem_rdata  input  INSTR_W  read data, valid the cycle after imem_en=1
redirect_valid  input  1  one-cycle pulse: flush and restart fetch
redirect_pc  input  ADDR_W  new fetch PC, sampled when redirect_valid=1
halt  input  1  level: suppress new memory reads
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_ready  input  1  downstream accepts the head entry
if_instr  output  INSTR_W  head instruction word
if_pc  output  ADDR_W  PC of the head instruction
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy
idle  output  1  1 when FIFO is empty and no read is in flight

Behaviour:
- Reset (reset=1 at an edge): fetch_pc<=RESET_PC, FIFO cleared (count=0), inflight<=0.
  - After reset: if_valid=0, fifo_count=0, idle=1, if_instr=0, if_pc=0.
  - imem_en=0 in any cycle where reset=1.
  - Reset mid-operation discards any in-flight response.
- Issue (combinational): imem_en = !reset && !redirect_valid && !halt && (count + inflight) < DEPTH.
  - imem_addr = fetch_pc.
- On issue: fetch_pc<=fetch_pc+1, wrapping 2^ADDR_W-1 -> 0 silently. inflight<=1, inflight_pc<=fetch_pc.
- No issue: inflight<=0; fetch_pc holds.
- Response: in the cycle after issue, if inflight=1 and redirect_valid=0, push {inflight_pc, imem_rdata} at the FIFO tail.
- Output: if_valid = (count != 0); if_instr/if_pc = head entry, combinationally from FIFO storage.
  - Head is stable while if_valid=1 and if_ready=0.
- Pop when if_valid && if_ready. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by construction because issue reserves a slot. A push into a full FIFO is a design error; flag it with an assertion.
- Latency: issue at cycle N -> push at end of N+1 -> if_valid at N+2. Sustained throughput is 1 instr/cycle when if_ready=1 continuously.
- Redirect (redirect_valid=1 in cycle R):
  - FIFO cleared, inflight<=0, fetch_pc<=redirect_pc. Any response returning in R is discarded; no issue in R.
  - R+1: imem_en=1 at redirect_pc (unless halt). R+3: if_valid=1 with if_pc=redirect_pc.
  - A pop in cycle R still occurs at the handshake level, but its entry belongs to the flushed stream; downstream ignores it.
- Redirect has priority over halt for fetch_pc update.
- Redirect on consecutive cycles: the last one wins.
- halt=1: no new issues. An in-flight read completes and is pushed. FIFO still drains. fetch_pc holds. Deasserting halt resumes at fetch_pc.
- idle = (count==0) && (inflight==0).
- fifo_count is registered occupancy, 0..DEPTH.

Test Plan:
- Reset release, memory preloaded mem[i]=i+19'h100, if_ready=1 -> imem_en=1 from first cycle; if_valid rises 2 cycles later; if_pc 0,1,2,3... with if_instr 0x100,0x101,... one per cycle, no bubbles.
- Backpressure: if_ready=0 for 10 cycles -> fifo_count settles at 4 (3 stored + 1 in flight, then 4); imem_en=0; if_pc=0 held stable. if_ready=1 -> PCs 0..N in order, none lost or duplicated.
- Redirect: redirect_valid pulse with redirect_pc=16'h0040 while 3 entries are buffered and a read is in flight -> fifo_count=0 next cycle; imem_addr=0x0040 at R+1; first if_pc after redirect = 0x0040; no stale PC appears.
- Wrap: redirect_pc=16'hFFFE -> if_pc sequence FFFE, FFFF, 0000, 0001.
- halt asserted for 5 cycles mid-stream -> no imem_en; the in-flight word is still delivered; after release fetch resumes at the next sequential PC; idle=1 once the FIFO drains during halt.
- reset asserted for 1 cycle mid-stream with full FIFO -> if_valid=0 and fifo_count=0 next cycle; fetch restarts at RESET_PC; the pre-reset in-flight word is never output.
